grn_cycle_ctrl: RTL and testbench

//  Drives a vector of GRN node instances through the reset_nos/start_s0/start_s1 strobe

---
 rtl/grn_cycle_ctrl_if.sv | 27 ++
 rtl/grn_cycle_ctrl.sv | 143 ++++++++++++++
 tb/tb_grn_cycle_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/grn_cycle_ctrl_if.sv
// Result port of the GRN cycle controller.
// Carries the meet/period pair on a valid/ready handshake.
interface grn_cycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic             res_timeout;
  logic [CNT_W-1:0] res_meet;
  logic [CNT_W-1:0] res_period;

  modport master (
    output res_valid,
    output res_meet,
    output res_period,
    output res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_meet,
    input  res_period,
    input  res_timeout,
    output res_ready
  );
endinterface

// File: rtl/grn_cycle_ctrl.sv
// GRN cycle controller: steps tortoise/hare node copies,
// finds the Floyd meeting step, then the attractor period.
module grn_cycle_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int SETTLE    = 1,
  parameter int MAX_STEPS = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  output logic               busy,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  grn_cycle_ctrl_if.master   res
);

  typedef enum logic [2:0] {
    IDLE, LOAD, STEP1, CMP1,
    STEP2, CMP2, WAIT, DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_STEPS);
  localparam logic [3:0] SET_L = 4'(SETTLE - 1);

  state_t           state;
  state_t           state_nx;
  state_t           ret;
  logic [3:0]       wait_cnt;
  logic [CNT_W-1:0] meet_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic             eq;

  assign eq = (s0_vec == s1_vec);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  state_nx = WAIT;
      STEP1: state_nx = WAIT;
      STEP2: state_nx = WAIT;
      WAIT:  if (wait_cnt == SET_L) state_nx = ret;
      CMP1: begin
        if (eq)                   state_nx = STEP2;
        else if (meet_cnt == MAX_C) state_nx = DONE;
        else                      state_nx = STEP1;
      end
      CMP2: begin
        if (eq)                  state_nx = DONE;
        else if (per_cnt == MAX_C) state_nx = DONE;
        else                     state_nx = STEP2;
      end
      DONE: begin
        if (res.res_valid && res.res_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and flags decode the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ret             <= IDLE;
      wait_cnt        <= '0;
      meet_cnt        <= '0;
      per_cnt         <= '0;
      busy            <= 1'b0;
      reset_nos       <= 1'b0;
      start_s0        <= 1'b0;
      start_s1        <= 1'b0;
      init_state      <= '0;
      res.res_valid   <= 1'b0;
      res.res_timeout <= 1'b0;
      res.res_meet    <= '0;
      res.res_period  <= '0;
    end else begin
      state         <= state_nx;
      busy          <= (state_nx != IDLE);
      reset_nos     <= (state_nx == LOAD);
      start_s0      <= (state_nx == STEP1);
      start_s1      <= (state_nx == STEP1) ||
                       (state_nx == STEP2);
      res.res_valid <= (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            init_state      <= init_vec;
            meet_cnt        <= '0;
            per_cnt         <= '0;
            res.res_meet    <= '0;
            res.res_period  <= '0;
            res.res_timeout <= 1'b0;
          end
        end
        LOAD: begin
          ret      <= STEP1;
          wait_cnt <= '0;
        end
        STEP1: begin
          ret      <= CMP1;
          wait_cnt <= '0;
          if (meet_cnt != MAX_C)
            meet_cnt <= meet_cnt + 1'b1;
        end
        STEP2: begin
          ret      <= CMP2;
          wait_cnt <= '0;
          if (per_cnt != MAX_C)
            per_cnt <= per_cnt + 1'b1;
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        CMP1: begin
          if (eq) begin
            res.res_meet <= meet_cnt;
          end else if (meet_cnt == MAX_C) begin
            res.res_meet    <= MAX_C;
            res.res_timeout <= 1'b1;
          end
        end
        CMP2: begin
          if (eq) begin
            res.res_period <= per_cnt;
          end else if (per_cnt == MAX_C) begin
            res.res_period  <= MAX_C;
            res.res_timeout <= 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grn_cycle_ctrl.sv
// Bench for grn_cycle_ctrl: abstract tortoise/hare node model,
// table of cycle shapes, scoreboard on the result port.
module tb_grn_cycle_ctrl;
  localparam int N    = 8;
  localparam int CW   = 16;
  localparam int MAXS = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] init_vec = '0;
  logic         busy, reset_nos;
  logic         start_s0, start_s1;
  logic [N-1:0] init_state, s0_vec, s1_vec;

  grn_cycle_ctrl_if #(.CNT_W(CW)) rif ();

  grn_cycle_ctrl #(
    .N_NODES(N), .CNT_W(CW),
    .SETTLE(1), .MAX_STEPS(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .init_vec(init_vec), .busy(busy),
    .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .res(rif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Node model: state index walks a transient of mu into a cycle of lam
  int         mu = 0, lam = 1;
  int         idx0 = 0, idx1 = 0;
  logic [7:0] base = '0;

  function automatic logic [7:0] vec_of(
    int i, logic [7:0] b, int m, int l);
    int p;
    p = (i < m) ? i : m + ((i - m) % l);
    return b + 8'(p);
  endfunction

  assign s0_vec = vec_of(idx0, base, mu, lam);
  assign s1_vec = vec_of(idx1, base, mu, lam);

  // The hare moves two states per joint strobe, one when stepped alone
  always @(posedge clk) begin
    if (reset_nos) begin
      idx0 <= 0;
      idx1 <= 0;
      base <= init_state;
    end else begin
      if (start_s0) idx0 <= idx0 + 1;
      if (start_s1) idx1 <= idx1 + (start_s0 ? 2 : 1);
    end
  end

  int         n_s0 = 0, n_s1 = 0, n_rn = 0;
  int         n_ph2s0 = 0, n_wide = 0;
  logic       ph2 = 1'b0;
  logic       ps0 = 1'b0, ps1 = 1'b0, prn = 1'b0;
  logic [7:0] seen_init = '0;

  always @(posedge clk) begin
    ps0 <= start_s0;
    ps1 <= start_s1;
    prn <= reset_nos;
    if ((start_s0 && ps0) || (start_s1 && ps1) ||
        (reset_nos && prn))
      n_wide <= n_wide + 1;
    if (reset_nos) begin
      n_s0      <= 0;
      n_s1      <= 0;
      n_ph2s0   <= 0;
      ph2       <= 1'b0;
      n_rn      <= n_rn + 1;
      seen_init <= init_state;
    end else begin
      if (start_s0) n_s0 <= n_s0 + 1;
      if (start_s1) n_s1 <= n_s1 + 1;
      if (start_s1 && !start_s0) ph2 <= 1'b1;
      if (start_s0 && ph2) n_ph2s0 <= n_ph2s0 + 1;
    end
  end

  typedef struct {
    logic [7:0] init;
    int         mu;
    int         lam;
    int         meet;
    int         per;
    int         to;
    int         ns0;
    int         ns1;
  } vec_t;

  vec_t tbl [6];
  vec_t exp_q [$];
  int   n_vec = 0, n_bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  task automatic launch(input vec_t v, output int c0);
    mu       = v.mu;
    lam      = v.lam;
    init_vec = v.init;
    exp_q.push_back(v);
    start = 1'b1;
    c0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input int c0, input int rn0,
                            input bit hold);
    vec_t e;
    bit   got;
    int   c1, lat;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      if (rif.res_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("valid_wait", 64'(0), 64'(1));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    c1 = cyc;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'(0), 64'(1));
      return;
    end
    e   = exp_q.pop_front();
    lat = 1 + 2 + (e.meet + e.per) * 3 + 1;
    chk("meet", 64'(rif.res_meet), 64'(e.meet));
    chk("period", 64'(rif.res_period), 64'(e.per));
    chk("timeout", 64'(rif.res_timeout), 64'(e.to));
    chk("latency", 64'(c1 - c0 + 1), 64'(lat));
    chk("s0_pulses", 64'(n_s0), 64'(e.ns0));
    chk("s1_pulses", 64'(n_s1), 64'(e.ns1));
    chk("load_pulses", 64'(n_rn - rn0), 64'(1));
    chk("init_state", 64'(seen_init), 64'(e.init));
    chk("s0_in_phase2", 64'(n_ph2s0), 64'(0));
    chk("wide_strobe", 64'(n_wide), 64'(0));
    if (hold) begin
      rif.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        start = (i == 1);
        @(negedge clk);
        chk("hold_valid", 64'(rif.res_valid), 64'(1));
        chk("hold_meet", 64'(rif.res_meet), 64'(e.meet));
        chk("hold_per", 64'(rif.res_period), 64'(e.per));
      end
      start = 1'b0;
      rif.res_ready = 1'b1;
    end
    @(negedge clk);
    chk("valid_drop", 64'(rif.res_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    if (hold) begin
      repeat (3) @(negedge clk);
      chk("start_ignored", 64'(n_rn - rn0), 64'(1));
      chk("still_idle", 64'(busy), 64'(0));
    end
  endtask

  task automatic run_one(input vec_t v, input bit hold);
    int c0, rn0;
    rn0 = n_rn;
    launch(v, c0);
    finish_run(c0, rn0, hold);
  endtask

  initial begin
    bit hit;
    int c0;
    tbl[0] = '{8'hA5, 0, 1,  1,  1, 0,  1,  2};
    tbl[1] = '{8'h00, 0, 3,  3,  3, 0,  3,  6};
    tbl[2] = '{8'h10, 2, 4,  4,  4, 0,  4,  8};
    tbl[3] = '{8'h40, 0, 32, 16, 0, 1, 16, 16};
    tbl[4] = '{8'h3C, 3, 5,  5,  5, 0,  5, 10};
    tbl[5] = '{8'hF0, 1, 2,  2,  2, 0,  2,  4};

    rif.res_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_reset_nos", 64'(reset_nos), 64'(0));
    chk("rst_s0", 64'(start_s0), 64'(0));
    chk("rst_s1", 64'(start_s1), 64'(0));
    chk("rst_valid", 64'(rif.res_valid), 64'(0));
    chk("rst_timeout", 64'(rif.res_timeout), 64'(0));
    chk("rst_meet", 64'(rif.res_meet), 64'(0));
    chk("rst_period", 64'(rif.res_period), 64'(0));
    chk("rst_init", 64'(init_state), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_one(tbl[i], 1'b0);

    run_one(tbl[1], 1'b1);
    run_one(tbl[1], 1'b0);

    launch(tbl[1], c0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (start_s1 && !start_s0) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reach_phase2", 64'(hit), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_s0", 64'(start_s0), 64'(0));
    chk("abort_s1", 64'(start_s1), 64'(0));
    chk("abort_load", 64'(reset_nos), 64'(0));
    chk("abort_valid", 64'(rif.res_valid), 64'(0));
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk("abort_quiet", 64'(start_s1), 64'(0));
    run_one(tbl[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
